// File: rtl/adc_conv_seq.sv
// Serial ADC conversion sequencer: wakes the divider, frames CS, deserialises, drops lead bits.
// Sample appears one clk after the last strobe event; if the output is still held, the new sample is dropped and overrun is flagged.
module adc_conv_seq #(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int GAP_STRB  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic              abort_i,
    input  logic              div_strb_i,
    input  logic              adc_sdata_i,
    output logic              div_en_o,
    output logic              adc_cs_n_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o
);
    localparam int FRAME = LEAD_BITS + DATA_W;
    localparam int BCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME - 1);
    localparam logic [3:0]     LAST_GAP = 4'(GAP_STRB - 1);

    typedef enum logic [1:0] {IDLE, WAKE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [3:0]       gapcnt_q, gapcnt_d;
    logic [FRAME-1:0] sh_q, sh_d;
    logic             strb_prev_q;
    logic             strb_ev;
    logic             frame_done;

    assign strb_ev    = div_strb_i & ~strb_prev_q;
    assign div_en_o   = (state_q != IDLE);
    assign busy_o     = (state_q != IDLE);
    assign adc_cs_n_o = (state_q != SHIFT);

    // History is held at zero while the divider is off so the first strobe after wake-up counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strb_prev_q <= 1'b0;
        end else begin
            strb_prev_q <= div_en_o & div_strb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            sh_q     <= sh_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        gapcnt_d   = gapcnt_q;
        sh_d       = sh_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i || cont_i) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (strb_ev) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    sh_d     = '0;
                end
            end
            SHIFT: begin
                if (strb_ev) begin
                    sh_d = (sh_q << 1) | FRAME'(adc_sdata_i);
                    if (bitcnt_q == LAST_BIT) begin
                        state_d    = GAP;
                        gapcnt_d   = '0;
                        frame_done = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end
            end
            GAP: begin
                if (strb_ev) begin
                    if (gapcnt_q == LAST_GAP) begin
                        state_d  = cont_i ? SHIFT : IDLE;
                        bitcnt_d = '0;
                    end else begin
                        gapcnt_d = gapcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over a completion on the same strobe: nothing is loaded.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            sh_d       = '0;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (frame_done && (!valid_o || ready_i)) begin
                data_o  <= sh_d[DATA_W-1:0];
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (frame_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (start_i) begin
                overrun_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_conv_seq.sv
// Bench for adc_conv_seq: scripted strobe/serial stimulus with random frames, timing and strobe widths.
module tb_adc_conv_seq;
    localparam int DW = 12;
    localparam int LB = 4;
    localparam int GS = 2;
    localparam int FR = DW + LB;

    logic          clk = 1'b0;
    logic          rst, start, cont, abort, strb, sdata, ready;
    logic          div_en, cs_n, busy, valid, overrun;
    logic [DW-1:0] data;

    adc_conv_seq #(.DATA_W(DW), .LEAD_BITS(LB), .GAP_STRB(GS)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .abort_i(abort),
        .div_strb_i(strb), .adc_sdata_i(sdata), .div_en_o(div_en), .adc_cs_n_o(cs_n),
        .busy_o(busy), .data_o(data), .valid_o(valid), .ready_i(ready), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] got_q[$];
    int            shift_ev = 0;
    logic          strb_seen = 1'b0;

    // Observed handshakes and strobe rising edges while CS is asserted.
    always @(negedge clk) begin
        if (valid && ready) got_q.push_back(data);
        if (strb && !strb_seen && !cs_n) shift_ev++;
        strb_seen = strb;
    end

    // Reference: a frame is FR bits MSB first; the sample is its low DW bits.
    function automatic logic [DW-1:0] ref_sample(input logic [FR-1:0] w);
        return w[DW-1:0];
    endfunction

    function automatic logic [FR-1:0] mk_frame(input logic [DW-1:0] d);
        logic [LB-1:0] lead;
        lead = LB'($urandom);
        return {lead, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic b, input int hi, input int lo);
        sdata = b;
        strb  = 1'b1;
        repeat (hi) tick();
        strb  = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic rpulse(input logic b);
        pulse(b, $urandom_range(1, 3), $urandom_range(1, 2));
    endtask

    task automatic send_bits(input logic [FR-1:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) rpulse(w[FR-1-i]);
    endtask

    task automatic start_one();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; cont = 0; abort = 0; strb = 0; sdata = 0; ready = 0;
        repeat (3) tick();
        n_cmp++;
        if ({div_en, cs_n, busy, valid, overrun} !== 5'b01000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 01000", {div_en, cs_n, busy, valid, overrun});
        end
        n_cmp++;
        if (data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 000", data); end
        rst = 1'b0;
        repeat (3) rpulse(1'b1);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_stay_idle: busy %b want 0", busy); end
    endtask

    task automatic test_single(input logic [FR-1:0] w);
        int ev0;
        ready = 1'b1;
        got_q.delete();
        start_one();
        n_cmp++;
        if ({busy, div_en, cs_n} !== 3'b111) begin
            n_bad++; $display("FAIL single_wake: busy/en/cs_n %b want 111", {busy, div_en, cs_n});
        end
        rpulse(1'b0);
        ev0 = shift_ev;
        send_bits(w, 0, FR - 1);
        sdata = w[0];
        strb  = 1'b1;
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", valid); end
        tick();
        n_cmp++;
        if (valid !== 1'b1 || data !== ref_sample(w)) begin
            n_bad++; $display("FAIL single_load: valid %b data %h want 1 %h", valid, data, ref_sample(w));
        end
        strb = 1'b0;
        tick();
        n_cmp++;
        if (shift_ev - ev0 !== FR) begin
            n_bad++; $display("FAIL single_cs_events: got %0d want %0d", shift_ev - ev0, FR);
        end
        for (int g = 0; g < GS; g++) rpulse(1'b0);
        n_cmp++;
        if ({div_en, busy} !== 2'b00) begin
            n_bad++; $display("FAIL single_idle: en/busy %b want 00", {div_en, busy});
        end
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_bad++; $display("FAIL single_count: got %0d want 1", got_q.size());
        end
    endtask

    task automatic test_continuous();
        logic [FR-1:0] w[3];
        int            ev0;
        w[0] = mk_frame(12'h001);
        w[1] = mk_frame(12'h800);
        w[2] = mk_frame(12'hFFF);
        got_q.delete();
        ready = 1'b1;
        cont  = 1'b1;
        tick();
        rpulse(1'b0);
        ev0 = shift_ev;
        for (int f = 0; f < 3; f++) begin
            send_bits(w[f], 0, FR / 2);
            if (f == 2) cont = 1'b0;
            send_bits(w[f], FR / 2, FR - FR / 2);
            for (int g = 0; g < GS; g++) begin
                n_cmp++;
                if (cs_n !== 1'b1) begin n_bad++; $display("FAIL cont_gap_cs: frame %0d gap %0d cs_n %b want 1", f, g, cs_n); end
                rpulse(1'b0);
            end
            n_cmp++;
            if (f < 2 && cs_n !== 1'b0) begin n_bad++; $display("FAIL cont_rearm: frame %0d cs_n %b want 0", f, cs_n); end
            else if (f == 2 && busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop: busy %b want 0", busy); end
        end
        n_cmp++;
        if (shift_ev - ev0 !== 3 * FR) begin
            n_bad++; $display("FAIL cont_cs_events: got %0d want %0d", shift_ev - ev0, 3 * FR);
        end
        n_cmp++;
        if (got_q.size() !== 3) begin n_bad++; $display("FAIL cont_count: got %0d want 3", got_q.size()); end
        for (int f = 0; f < 3 && f < got_q.size(); f++) begin
            n_cmp++;
            if (got_q[f] !== ref_sample(w[f])) begin
                n_bad++; $display("FAIL cont_data%0d: got %h want %h", f, got_q[f], ref_sample(w[f]));
            end
        end
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL cont_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        logic [FR-1:0] w1, w2;
        w1 = mk_frame(DW'($urandom));
        w2 = mk_frame(~w1[DW-1:0]);
        got_q.delete();
        ready = 1'b0;
        cont  = 1'b1;
        tick();
        rpulse(1'b0);
        send_bits(w1, 0, FR);
        n_cmp++;
        if ({valid, overrun} !== 2'b10 || data !== ref_sample(w1)) begin
            n_bad++; $display("FAIL ovr_first: valid/ovr %b data %h want 10 %h", {valid, overrun}, data, ref_sample(w1));
        end
        for (int g = 0; g < GS; g++) rpulse(1'b0);
        send_bits(w2, 0, FR / 2);
        cont = 1'b0;
        send_bits(w2, FR / 2, FR - FR / 2);
        n_cmp++;
        if ({valid, overrun} !== 2'b11 || data !== ref_sample(w1)) begin
            n_bad++; $display("FAIL ovr_second: valid/ovr %b data %h want 11 %h", {valid, overrun}, data, ref_sample(w1));
        end
        for (int g = 0; g < GS; g++) rpulse(1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || got_q.size() !== 1) begin
            n_bad++; $display("FAIL ovr_drain: valid %b count %0d want 0 1", valid, got_q.size());
        end
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        start_one();
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        logic [FR-1:0] w, w2, w3;
        w  = mk_frame(DW'($urandom));
        w2 = mk_frame(DW'($urandom));
        w3 = mk_frame(DW'($urandom));
        got_q.delete();
        ready = 1'b1;
        start_one();
        rpulse(1'b0);
        send_bits(w, 0, 7);
        sdata = w[FR-8];
        strb  = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({cs_n, div_en, busy} !== 3'b100) begin
            n_bad++; $display("FAIL abort_mid: cs_n/en/busy %b want 100", {cs_n, div_en, busy});
        end
        strb = 1'b0;
        tick();
        repeat (3) rpulse(1'b1);
        n_cmp++;
        if (valid !== 1'b0 || got_q.size() !== 0) begin
            n_bad++; $display("FAIL abort_no_valid: valid %b count %0d want 0 0", valid, got_q.size());
        end
        start_one();
        rpulse(1'b0);
        send_bits(w2, 0, FR);
        for (int g = 0; g < GS; g++) rpulse(1'b0);
        n_cmp++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== ref_sample(w2))) begin
            n_bad++; $display("FAIL abort_clean_frame: count %0d want 1 value %h", got_q.size(), ref_sample(w2));
        end
        start_one();
        rpulse(1'b0);
        send_bits(w3, 0, FR - 1);
        sdata = w3[0];
        strb  = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        strb  = 1'b0;
        tick();
        n_cmp++;
        if ({valid, busy} !== 2'b00 || got_q.size() !== 1) begin
            n_bad++; $display("FAIL abort_last_bit: valid/busy %b count %0d want 00 1", {valid, busy}, got_q.size());
        end
    endtask

    task automatic test_slow_strobe();
        logic [FR-1:0] w1, w2;
        int            ev0;
        w1 = mk_frame(DW'($urandom));
        w2 = mk_frame(DW'($urandom));
        got_q.delete();
        ready = 1'b0;
        cont  = 1'b1;
        tick();
        pulse(1'b0, 5, 2);
        ev0 = shift_ev;
        for (int i = 0; i < FR; i++) pulse(w1[FR-1-i], 5, $urandom_range(1, 3));
        n_cmp++;
        if (valid !== 1'b1 || data !== ref_sample(w1)) begin
            n_bad++; $display("FAIL slow_frame1: valid %b data %h want 1 %h", valid, data, ref_sample(w1));
        end
        for (int g = 0; g < GS; g++) pulse(1'b0, 5, 2);
        for (int i = 0; i < FR - 1; i++) pulse(w2[FR-1-i], 5, $urandom_range(1, 3));
        sdata = w2[0];
        strb  = 1'b1;
        ready = 1'b1;
        cont  = 1'b0;
        tick();
        ready = 1'b0;
        n_cmp++;
        if ({valid, overrun} !== 2'b10 || data !== ref_sample(w2)) begin
            n_bad++; $display("FAIL slow_same_cycle_load: valid/ovr %b data %h want 10 %h", {valid, overrun}, data, ref_sample(w2));
        end
        repeat (4) tick();
        strb = 1'b0;
        tick();
        for (int g = 0; g < GS; g++) pulse(1'b0, 5, 2);
        n_cmp++;
        if (shift_ev - ev0 !== 2 * FR) begin
            n_bad++; $display("FAIL slow_shift_count: got %0d want %0d", shift_ev - ev0, 2 * FR);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++;
        if (got_q.size() !== 2 || (got_q.size() == 2 && (got_q[0] !== ref_sample(w1) || got_q[1] !== ref_sample(w2)))) begin
            n_bad++; $display("FAIL slow_order: count %0d want 2 values %h %h", got_q.size(), ref_sample(w1), ref_sample(w2));
        end
    endtask

    task automatic test_async_reset();
        logic [FR-1:0] w;
        w = mk_frame(DW'($urandom) | DW'(1));
        ready = 1'b0;
        start_one();
        rpulse(1'b0);
        send_bits(w, 0, FR);
        for (int g = 0; g < GS; g++) rpulse(1'b0);
        start_one();
        rpulse(1'b0);
        send_bits(w, 0, 5);
        n_cmp++;
        if ({valid, cs_n} !== 2'b10) begin
            n_bad++; $display("FAIL arst_pre: valid/cs_n %b want 10", {valid, cs_n});
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({div_en, cs_n, busy, valid, overrun} !== 5'b01000 || data !== '0) begin
            n_bad++; $display("FAIL arst_immediate: ctrl %b data %h want 01000 000", {div_en, cs_n, busy, valid, overrun}, data);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (4) rpulse(1'b1);
        n_cmp++;
        if ({div_en, cs_n, busy} !== 3'b010) begin
            n_bad++; $display("FAIL arst_stay_idle: en/cs_n/busy %b want 010", {div_en, cs_n, busy});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single({4'b0000, 12'hA5C});
        test_single(mk_frame(DW'($urandom)));
        test_single(mk_frame(DW'($urandom)));
        test_continuous();
        test_overrun();
        test_abort();
        test_slow_strobe();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_conv_seq.md
Name: adc_conv_seq

Overview:
Conversion sequencer for the serial ADC front end. It enables the external clock divider and paces every action on the divider strobe. It frames each conversion with an active-low chip select, deserialises the ADC bit stream and drops the leading bits. The finished sample goes to the downstream sample path over a valid/ready handshake, in either single-shot or continuous mode.

Parameters:
DATA_W, 12, sample width in bits delivered on data_o (1..16).
LEAD_BITS, 4, leading serial bits per frame, discarded (0..7).
GAP_STRB, 2, strobe events with adc_cs_n_o high between frames (1..15).

Ports:
clk_i  in  1  system clock; all logic on posedge.
rst_i  in  1  asynchronous active-high reset.
start_i  in  1  single-cycle request for one conversion; sampled in IDLE only.
cont_i  in  1  level; continuous mode, re-arms after every GAP.
abort_i  in  1  single-cycle; terminate the current frame.
div_strb_i  in  1  divider strobe (level, multi-cycle allowed); asynchronous phase relative to frame.
adc_sdata_i  in  1  ADC serial data, MSB first, valid at strobe event.
div_en_o  out  1  divider enable.
adc_cs_n_o  out  1  ADC chip select, active low.
busy_o  out  1  high in any state except IDLE.
data_o  out  DATA_W  captured sample.
valid_o  out  1  data_o valid; held until ready_i.
ready_i  in  1  downstream accept.
overrun_o  out  1  sticky; set when a frame completes while the output register is still full; cleared by rst_i or start_i.

Behaviour:
- Reset (async, rst_i=1): state IDLE, div_en_o=0, adc_cs_n_o=1, busy_o=0, data_o=0, valid_o=0, overrun_o=0, counters=0, strobe history=0.
- Strobe event: div_strb_i=1 while its registered previous value=0 (rising-edge detect). The event acts in the same cycle it is detected. The history register clears whenever div_en_o=0.
- FSM states: IDLE, WAKE, SHIFT, GAP.
- IDLE: outputs idle. On start_i=1 or cont_i=1, go to WAKE, div_en_o=1 from the next cycle.
- WAKE: div_en_o=1, cs_n=1. Wait for the first strobe event, then go to SHIFT with bitcnt=0. The waking event itself samples nothing.
- SHIFT: cs_n=0. Each event shifts adc_sdata_i into an internal shift register LSB-in, so the MSB arrives first, and increments bitcnt.
  - On the event with bitcnt=LEAD_BITS+DATA_W-1, the frame is complete and the state goes to GAP with gapcnt=0.
  - The result is the low DATA_W bits including the bit shifted in at that event.
- Output register:
  - If the register is free, or valid_o&&ready_i in the same cycle, data_o loads on the cycle after frame completion and valid_o=1. Latency is one clk_i from the final strobe event.
  - If the register is full and ready_i=0, the new result is dropped, data_o keeps its old value and overrun_o is set.
  - valid_o clears on the cycle after valid_o&&ready_i, unless a new load happens in that same cycle.
- GAP: cs_n=1, counts strobe events. When gapcnt=GAP_STRB-1 at an event:
  - cont_i=1: go to SHIFT, bitcnt=0. The next frame's first bit is the following event.
  - cont_i=0: go to IDLE, div_en_o=0 next cycle.
- abort_i (any non-IDLE state): next cycle IDLE, cs_n=1, div_en_o=0, partial shift data discarded. valid_o/data_o are unaffected. abort_i has priority over a simultaneous frame completion, so no load occurs.
- start_i outside IDLE is ignored. cont_i dropping mid-frame lets the current frame finish, then the block returns to IDLE after GAP.
- bitcnt width is ceil(log2(LEAD_BITS+DATA_W)); gapcnt is 4 bits. There is no wrap inside a frame.

Test Plan:
- DATA_W=12, LEAD_BITS=4, GAP_STRB=2. Single start_i, serial stream 0000_1010_0101_1100 -> data_o=0xA5C, valid_o one clk after the 16th SHIFT event, exactly 16 events with cs_n=0. After 2 GAP events: IDLE, div_en_o=0.
- cont_i=1, ready_i=1, 3 frames 0x001/0x800/0xFFF -> three valid_o pulses, values in order, cs_n high for exactly 2 events between frames, overrun_o=0.
- cont_i=1, ready_i=0 for 2 frames -> data_o holds the first sample, overrun_o=1 after the second frame completes. The next start_i in IDLE clears overrun_o.
- abort_i at bit 7 of a frame -> next cycle adc_cs_n_o=1, div_en_o=0, no valid_o. A following start_i gives a clean frame with the correct value.
- Strobe held high for 5 clk_i cycles per period -> exactly one shift per period, no double count. ready_i asserted on the same cycle as a new load -> new value is presented, valid_o stays 1.
- rst_i asserted mid-SHIFT, asynchronously between clock edges -> all outputs return to reset values immediately. After release, the block stays IDLE until start_i.
